// File: rtl/bldc_pkg.sv
// bldc_pkg: state encodings, fault codes and sector stepping helpers shared by the sequencer
package bldc_pkg;

    localparam int SECTOR_W = 3;
    localparam logic [15:0] Q15_MAX = 16'h7FFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_STOP  = 3'd4,
        S_FAULT = 3'd5
    } seq_state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_EXT   = 2'b01;
    localparam logic [1:0] FC_STALL = 2'b10;

    function automatic logic [SECTOR_W-1:0] next_sector(input logic [SECTOR_W-1:0] s);
        return (s >= 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [SECTOR_W-1:0] prev_sector(input logic [SECTOR_W-1:0] s);
        return (s == 3'd0 || s > 3'd5) ? 3'd5 : s - 3'd1;
    endfunction

endpackage

// File: rtl/vref_slew_limiter.sv
// vref_slew_limiter: paces vref toward a saturated Q1.15 target in bounded steps without overshoot
module vref_slew_limiter
    import bldc_pkg::*;
#(
    parameter int unsigned SLEW_DIV  = 100,
    parameter int unsigned SLEW_STEP = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [15:0] target,
    output logic [15:0] value
);

    localparam logic [15:0] STEP = 16'(SLEW_STEP);

    logic [31:0] div;
    logic        tick;
    logic [15:0] goal;
    logic [15:0] up;
    logic [15:0] down;
    logic [15:0] stepped;

    // Clamp the target to the positive Q1.15 range and limit each move to the smaller of gap and step.
    always_comb begin
        tick    = div == 32'(SLEW_DIV - 1);
        goal    = target > Q15_MAX ? Q15_MAX : target;
        up      = goal - value;
        down    = value - goal;
        stepped = goal > value ? value + (up > STEP ? STEP : up)
                               : value - (down > STEP ? STEP : down);
    end

    // Divider paces the ticks; clear zeroes the output at once and restarts the pacing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div   <= '0;
            value <= '0;
        end else if (clear) begin
            div   <= '0;
            value <= '0;
        end else begin
            div <= tick ? '0 : div + 32'd1;
            if (tick) value <= stepped;
        end
    end

endmodule

// File: rtl/bldc_commutation_sequencer.sv
// bldc_commutation_sequencer: align / open-loop ramp / sensed run / ramp-down sequencer for the 6-step PWM stage.
// Optional stall timeout in RUN is built when STALL_DETECT_EN is defined.
module bldc_commutation_sequencer
    import bldc_pkg::*;
#(
    parameter int unsigned ALIGN_CYCLES      = 5_000_000,
    parameter int unsigned RAMP_START_PERIOD = 2_000_000,
    parameter int unsigned RAMP_END_PERIOD   = 200_000,
    parameter int unsigned RAMP_STEP         = 50_000,
    parameter int unsigned SLEW_DIV          = 100,
    parameter int unsigned SLEW_STEP         = 16
`ifdef STALL_DETECT_EN
    ,
    parameter int unsigned STALL_CYCLES      = 10_000_000
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        fault_n,
    input  logic        fault_clr,
    input  logic        direction,
    input  logic [2:0]  sensed_sector,
    input  logic        sensed_valid,
    input  logic [15:0] align_vref,
    input  logic [15:0] ramp_vref,
    input  logic [15:0] vref_cmd,
    output logic [2:0]  sector_out,
    output logic [15:0] vref_out,
    output logic        pwm_enable,
    output logic [2:0]  state,
    output logic [1:0]  fault_cause
);

    seq_state_t  st;
    seq_state_t  nxt;
    logic [31:0] cnt;
    logic [31:0] period;
    logic [31:0] next_period;
    logic        en_reg;
    logic        sensed_ok;
    logic        commute;
    logic        handoff;
    logic        stall_hit;
    logic        clear;
    logic [2:0]  step_sector;
    logic [15:0] target;

    assign sensed_ok   = sensed_valid && sensed_sector <= 3'd5;
    assign step_sector = direction ? prev_sector(sector_out) : next_sector(sector_out);
    assign commute     = cnt == period - 32'd1;
    assign handoff     = period == RAMP_END_PERIOD && sensed_ok && sensed_sector == step_sector;
    assign next_period = period >= RAMP_END_PERIOD + RAMP_STEP ? period - RAMP_STEP : RAMP_END_PERIOD;

`ifdef STALL_DETECT_EN
    logic [31:0] stall_cnt;
    logic        moved;

    assign moved     = sensed_ok && sensed_sector != sector_out;
    assign stall_hit = st == S_RUN && !moved && stall_cnt == STALL_CYCLES - 1;

    // Clocks spent in RUN since the decoder last reported a new sector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt <= '0;
        else stall_cnt <= (st != S_RUN || moved) ? '0 : stall_cnt + 32'd1;
    end
`else
    assign stall_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= S_IDLE;
        else st <= nxt;
    end

    // Next state: external fault beats stop, stop beats start.
    always_comb begin
        nxt = st;
        if (!fault_n) nxt = S_FAULT;
        else begin
            case (st)
                S_IDLE:  nxt = (start && !stop) ? S_ALIGN : S_IDLE;
                S_ALIGN: nxt = stop ? S_STOP : (cnt == ALIGN_CYCLES - 1) ? S_RAMP : S_ALIGN;
                S_RAMP:  nxt = stop ? S_STOP : (commute && handoff) ? S_RUN : S_RAMP;
                S_RUN:   nxt = stop ? S_STOP : stall_hit ? S_FAULT : S_RUN;
                S_STOP:  nxt = vref_out == 16'd0 ? S_IDLE : S_STOP;
                S_FAULT: nxt = fault_clr ? S_IDLE : S_FAULT;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Per-state vref target; entering IDLE or FAULT drops vref to zero on the same edge.
    always_comb begin
        target = st == S_ALIGN ? align_vref : st == S_RAMP ? ramp_vref : st == S_RUN ? vref_cmd : 16'd0;
        clear  = nxt == S_IDLE || nxt == S_FAULT;
    end

    // Counters, commutation, enable and fault cause; updates are skipped when leaving for STOP/FAULT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            period      <= '0;
            sector_out  <= '0;
            en_reg      <= 1'b0;
            fault_cause <= FC_NONE;
        end else begin
            en_reg      <= nxt inside {S_ALIGN, S_RAMP, S_RUN, S_STOP};
            fault_cause <= !fault_n ? FC_EXT :
                           (st == S_RUN && nxt == S_FAULT) ? FC_STALL :
                           (st == S_FAULT && nxt == S_IDLE) ? FC_NONE : fault_cause;
            case (st)
                S_IDLE: if (nxt == S_ALIGN) begin
                    cnt        <= '0;
                    sector_out <= '0;
                end
                S_ALIGN: begin
                    cnt <= nxt == S_RAMP ? '0 : cnt + 32'd1;
                    if (nxt == S_RAMP) period <= RAMP_START_PERIOD;
                end
                S_RAMP: if (nxt == S_RAMP || nxt == S_RUN) begin
                    cnt <= commute ? '0 : cnt + 32'd1;
                    if (commute) begin
                        sector_out <= step_sector;
                        period     <= next_period;
                    end
                end
                S_RUN: if (nxt == S_RUN && sensed_ok) sector_out <= sensed_sector;
                default: ;
            endcase
        end
    end

    assign state      = st;
    assign pwm_enable = en_reg & fault_n;

    vref_slew_limiter #(
        .SLEW_DIV  (SLEW_DIV),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .target  (target),
        .value   (vref_out)
    );

endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// tb_bldc_commutation_sequencer: directed sequence with randomized vref targets against a closed-form model
module tb_bldc_commutation_sequencer;

    localparam int STEP = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        fault_n = 1'b1;
    logic        fault_clr = 1'b0;
    logic        direction = 1'b0;
    logic        sensed_valid = 1'b0;
    logic [2:0]  sensed_sector = 3'd0;
    logic [15:0] align_vref = 16'd0;
    logic [15:0] ramp_vref = 16'd0;
    logic [15:0] vref_cmd = 16'd0;
    logic [2:0]  sector_out;
    logic [2:0]  state;
    logic [15:0] vref_out;
    logic        pwm_enable;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int a, rv, v, uv, v40, v80;

    always #5 clk = ~clk;

    bldc_commutation_sequencer #(
        .ALIGN_CYCLES      (100),
        .RAMP_START_PERIOD (400),
        .RAMP_END_PERIOD   (100),
        .RAMP_STEP         (100),
        .SLEW_DIV          (1),
        .SLEW_STEP         (STEP)
`ifdef STALL_DETECT_EN
        ,
        .STALL_CYCLES      (500)
`endif
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .fault_n       (fault_n),
        .fault_clr     (fault_clr),
        .direction     (direction),
        .sensed_sector (sensed_sector),
        .sensed_valid  (sensed_valid),
        .align_vref    (align_vref),
        .ramp_vref     (ramp_vref),
        .vref_cmd      (vref_cmd),
        .sector_out    (sector_out),
        .vref_out      (vref_out),
        .pwm_enable    (pwm_enable),
        .state         (state),
        .fault_cause   (fault_cause)
    );

    // vref after k slew ticks from v0 toward a saturated target
    function automatic int slew_after(input int v0, input int tgt, input int k);
        int g;
        g = tgt > 32767 ? 32767 : tgt;
        if (g > v0) return (v0 + k * STEP < g) ? v0 + k * STEP : g;
        return (v0 - k * STEP > g) ? v0 - k * STEP : g;
    endfunction

    // open-loop sector after k clocks in RAMP: periods 400,300,200 then 100 forever
    function automatic int ramp_sector(input int k, input bit dir);
        int p, due, s;
        p = 400;
        due = 400;
        s = 0;
        while (due <= k) begin
            s = dir ? (s + 5) % 6 : (s + 1) % 6;
            p = (p - 100 > 100) ? p - 100 : 100;
            due += p;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int k);
        repeat (k - t) @(negedge clk);
        t = k;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_sector", 32'(sector_out), 0);
        chk("rst_vref", 32'(vref_out), 0);
        chk("rst_enable", 32'(pwm_enable), 0);
        chk("rst_cause", 32'(fault_cause), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // alignment
        a = 8000;
        rv = int'($urandom_range(0, 65535));
        align_vref = 16'(a);
        ramp_vref = 16'(rv);
        vref_cmd = 16'h9000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        chk("align_state", 32'(state), 1);
        chk("align_enable", 32'(pwm_enable), 1);
        chk("align_sector", 32'(sector_out), 0);
        adv(7);
        chk("align_vref7", 32'(vref_out), slew_after(0, a, 7));
        adv(8);
        chk("align_vref8", 32'(vref_out), 8000);
        adv(99);
        chk("align_hold", 32'(state), 1);
        adv(100);
        chk("ramp_entry", 32'(state), 2);

        // open-loop ramp, forward
        t = 0;
        adv(399);
        chk("ramp_vref", 32'(vref_out), slew_after(slew_after(0, a, 100), rv, 399));
        chk("ramp_s399", 32'(sector_out), ramp_sector(399, 0));
        adv(400);
        chk("ramp_s400", 32'(sector_out), ramp_sector(400, 0));
        adv(699);
        sensed_sector = 3'd2;
        sensed_valid = 1'b1;
        adv(700);
        chk("no_early_handoff", 32'(state), 2);
        chk("ramp_s700", 32'(sector_out), ramp_sector(700, 0));
        sensed_valid = 1'b0;
        for (int k = 800; k <= 1200; k += 100) begin
            adv(k);
            chk("ramp_sector", 32'(sector_out), ramp_sector(k, 0));
        end
        chk("ramp_floor_state", 32'(state), 2);
        sensed_sector = 3'(ramp_sector(1300, 0));
        sensed_valid = 1'b1;
        adv(1299);
        chk("pre_handoff", 32'(state), 2);
        adv(1300);
        chk("handoff_state", 32'(state), 3);
        chk("handoff_sector", 32'(sector_out), ramp_sector(1300, 0));

        // sensed run
        uv = slew_after(slew_after(0, a, 100), rv, 1300);
        t = 0;
        sensed_sector = 3'd3;
        adv(1);
        chk("run_s3", 32'(sector_out), 3);
        sensed_sector = 3'd4;
        adv(2);
        chk("run_s4", 32'(sector_out), 4);
        sensed_valid = 1'b0;
        sensed_sector = 3'd5;
        adv(4);
        chk("run_invalid_hold", 32'(sector_out), 4);
        sensed_valid = 1'b1;
        sensed_sector = 3'd7;
        adv(6);
        chk("run_s7_ignored", 32'(sector_out), 4);
        sensed_sector = 3'd6;
        adv(7);
        chk("run_s6_ignored", 32'(sector_out), 4);
        sensed_sector = 3'd4;
        adv(8);
        chk("run_vref_slew", 32'(vref_out), slew_after(uv, 32'h9000, 8));
        adv(40);
        v40 = slew_after(uv, 32'h9000, 40);
        chk("run_vref_sat", 32'(vref_out), v40);
        vref_cmd = 16'd20000;
        adv(42);
        chk("run_retarget", 32'(vref_out), slew_after(v40, 20000, 2));
        adv(80);
        v80 = slew_after(v40, 20000, 40);
        chk("run_vref_20000", 32'(vref_out), v80);

        // ramp-down
        stop = 1'b1;
        sensed_sector = 3'd5;
        adv(81);
        chk("stop_state", 32'(state), 4);
        chk("stop_vref_start", 32'(vref_out), v80);
        chk("stop_sector_frozen", 32'(sector_out), 4);
        adv(91);
        chk("stop_vref_fall", 32'(vref_out), slew_after(v80, 0, 10));
        chk("stop_enable", 32'(pwm_enable), 1);
        adv(101);
        chk("stop_vref_zero", 32'(vref_out), 0);
        chk("stop_still", 32'(state), 4);
        adv(102);
        chk("stop_idle", 32'(state), 0);
        chk("stop_idle_enable", 32'(pwm_enable), 0);
        start = 1'b1;
        adv(105);
        chk("stop_beats_start", 32'(state), 0);
        start = 1'b0;
        stop = 1'b0;
        sensed_valid = 1'b0;

        // fault during reverse ramp
        direction = 1'b1;
        a = int'($urandom_range(1000, 32767));
        align_vref = 16'(a);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        adv(100);
        chk("rev_ramp_entry", 32'(state), 2);
        t = 0;
        adv(400);
        chk("rev_sector", 32'(sector_out), ramp_sector(400, 1));
        adv(450);
        fault_n = 1'b0;
        #1;
        chk("fault_kill_enable", 32'(pwm_enable), 0);
        chk("fault_same_cycle_state", 32'(state), 2);
        adv(451);
        chk("fault_state", 32'(state), 5);
        chk("fault_cause_ext", 32'(fault_cause), 1);
        chk("fault_vref", 32'(vref_out), 0);
        fault_clr = 1'b1;
        adv(453);
        chk("fault_clr_ignored", 32'(state), 5);
        fault_n = 1'b1;
        adv(454);
        chk("fault_cleared", 32'(state), 0);
        chk("fault_cause_clear", 32'(fault_cause), 0);
        fault_clr = 1'b0;

        // earliest handoff at the floor, then stall or async reset
        direction = 1'b0;
        sensed_sector = 3'd4;
        sensed_valid = 1'b1;
        a = int'($urandom_range(0, 32767));
        rv = int'($urandom_range(0, 65535));
        v = int'($urandom_range(1000, 65535));
        align_vref = 16'(a);
        ramp_vref = 16'(rv);
        vref_cmd = 16'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        adv(100);
        t = 0;
        adv(900);
        chk("floor_pre_state", 32'(state), 2);
        chk("floor_pre_sector", 32'(sector_out), ramp_sector(900, 0));
        adv(1000);
        chk("floor_handoff", 32'(state), 3);
        chk("floor_sector", 32'(sector_out), 4);
        adv(1200);
        chk("run2_state", 32'(state), 3);
        chk("run2_vref", 32'(vref_out), slew_after(slew_after(slew_after(0, a, 100), rv, 1000), v, 200));
`ifdef STALL_DETECT_EN
        adv(1499);
        chk("stall_pre", 32'(state), 3);
        adv(1500);
        chk("stall_fault", 32'(state), 5);
        chk("stall_cause", 32'(fault_cause), 2);
        fault_clr = 1'b1;
        adv(1501);
        chk("stall_cleared", 32'(state), 0);
        fault_clr = 1'b0;
        start = 1'b1;
        adv(1502);
        start = 1'b0;
`else
        adv(1500);
        chk("no_stall_state", 32'(state), 3);
        chk("no_stall_cause", 32'(fault_cause), 0);
`endif
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_sector", 32'(sector_out), 0);
        chk("async_vref", 32'(vref_out), 0);
        chk("async_enable", 32'(pwm_enable), 0);
        chk("async_cause", 32'(fault_cause), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
